// File: rtl/gate_op_arbiter.sv
// Round-robin arbiter that time-shares one registered bitwise logic unit
// among NUM_REQ requesters over valid/ready request and response channels.
module gate_op_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ*3-1:0]     req_op,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [WIDTH-1:0]         resp_y,
  output logic [ID_W-1:0]          resp_id,
  output logic                     busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state, next_state;

  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    win;
  logic [ID_W-1:0]    off;
  logic [ID_W:0]      sum;
  logic [NUM_REQ-1:0] rot;
  logic               found;
  logic               any_valid;

  logic [WIDTH-1:0]   sel_a, sel_b;
  logic [2:0]         sel_op;
  logic [WIDTH-1:0]   cap_a, cap_b;
  logic [2:0]         cap_op;
  logic [ID_W-1:0]    cap_id;
  logic [WIDTH-1:0]   result;

  // Rotate the valid vector so bit 0 is rr_ptr, then map the first hit back.
  always_comb begin
    any_valid = |req_valid;
    rot       = NUM_REQ'({req_valid, req_valid} >> rr_ptr);
    found     = 1'b0;
    off       = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        off   = ID_W'(i);
      end
    end
    sum = {1'b0, rr_ptr} + {1'b0, off};
    if (sum >= (ID_W+1)'(NUM_REQ))
      sum = sum - (ID_W+1)'(NUM_REQ);
    win = sum[ID_W-1:0];
  end

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win == ID_W'(i)) begin
        sel_a  = req_a[i*WIDTH +: WIDTH];
        sel_b  = req_b[i*WIDTH +: WIDTH];
        sel_op = req_op[i*3 +: 3];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && !rst && any_valid)
      req_ready[win] = 1'b1;
  end

  always_comb begin
    case (cap_op)
      3'd0:    result = ~(cap_a & cap_b);
      3'd1:    result = cap_a & cap_b;
      3'd2:    result = cap_a | cap_b;
      3'd3:    result = ~(cap_a | cap_b);
      3'd4:    result = cap_a ^ cap_b;
      3'd5:    result = ~(cap_a ^ cap_b);
      3'd6:    result = ~cap_a;
      default: result = cap_a;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_valid) next_state = EXEC;
      EXEC:    next_state = RESP;
      RESP:    if (resp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= '0;
      resp_valid <= 1'b0;
      resp_y     <= '0;
      resp_id    <= '0;
      cap_a      <= '0;
      cap_b      <= '0;
      cap_op     <= '0;
      cap_id     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            cap_a  <= sel_a;
            cap_b  <= sel_b;
            cap_op <= sel_op;
            cap_id <= win;
          end
        end
        EXEC: begin
          resp_y     <= result;
          resp_id    <= cap_id;
          resp_valid <= 1'b1;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            rr_ptr     <= (cap_id == ID_W'(NUM_REQ-1)) ? '0 : cap_id + ID_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
